lpf_run_sequencer: RTL and testbench

- Control sequencer for one self-trigger low-pass filter channel; sits between the channel configuration registers and the filter's reset/enable inputs.
- Flushes filter state, waits a programmable settling interval while the IIR output converges, then flags the output valid for the downstream self-trigger.
- Supports pause/resume without losing filter state, and resynchronisation on request.

---
 rtl/lpf_run_sequencer.sv | 152 +++++++++++++++
 tb/tb_lpf_run_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpf_run_sequencer.sv
// Run sequencer for one self-trigger low-pass filter channel: flushes the filter,
// waits a programmable settle interval, then flags the filtered output as usable.
module lpf_run_sequencer #(
    parameter int unsigned         FLUSH_CYCLES   = 4,
    parameter int unsigned         SETTLE_W       = 16,
    parameter logic [SETTLE_W-1:0] SETTLE_DEFAULT = SETTLE_W'(2048)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run_en,
    input  logic                resync,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [SETTLE_W-1:0] cfg_settle,
    output logic                flt_reset,
    output logic                flt_enable,
    output logic                out_valid,
    output logic                busy,
    output logic [2:0]          state_o
);

    localparam int unsigned      FLUSH_W    = $clog2(FLUSH_CYCLES + 1);
    localparam int unsigned      CNT_W      = (SETTLE_W > FLUSH_W) ? SETTLE_W : FLUSH_W;
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLUSH  = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        PAUSE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0]    settle_last;
    logic                flt_reset_q, flt_reset_d;
    logic                flt_enable_q, flt_enable_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                cfg_ready_q, cfg_ready_d;

    // A zero settle length behaves as a single settle cycle.
    assign settle_last = (settle_q == '0) ? '0 : CNT_W'(settle_q - SETTLE_W'(1));

    // Next state, counter and settle register; resync outranks a run_en drop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;

        if (cfg_valid && cfg_ready_q) begin
            settle_d = cfg_settle;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (run_en) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (resync) begin
                    cnt_d = '0;
                end else if (!run_en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == FLUSH_LAST) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SETTLE: begin
                if (resync) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else if (!run_en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == settle_last) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                cnt_d = '0;
                if (resync) begin
                    state_d = FLUSH;
                end else if (!run_en) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                cnt_d = '0;
                if (resync) begin
                    state_d = FLUSH;
                end else if (run_en) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies track state_q.
    always_comb begin
        flt_reset_d  = (state_d == IDLE) || (state_d == FLUSH);
        flt_enable_d = (state_d == SETTLE) || (state_d == RUN);
        out_valid_d  = (state_d == RUN);
        busy_d       = (state_d == FLUSH) || (state_d == SETTLE);
        cfg_ready_d  = !busy_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            settle_q     <= SETTLE_DEFAULT;
            flt_reset_q  <= 1'b1;
            flt_enable_q <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            cfg_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            settle_q     <= settle_d;
            flt_reset_q  <= flt_reset_d;
            flt_enable_q <= flt_enable_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            cfg_ready_q  <= cfg_ready_d;
        end
    end

    assign flt_reset  = flt_reset_q;
    assign flt_enable = flt_enable_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign cfg_ready  = cfg_ready_q;
    assign state_o    = 3'(state_q);

endmodule

// File: tb/tb_lpf_run_sequencer.sv
// Self-checking bench for lpf_run_sequencer: timestamp-based mode model checked
// every cycle, plus directed latency checks with hand-computed cycle counts.
module tb_lpf_run_sequencer;

    localparam int FLUSH_N  = 4;
    localparam int DEF_SETL = 2048;
    localparam int M_IDLE   = 0;
    localparam int M_FLUSH  = 1;
    localparam int M_SETTLE = 2;
    localparam int M_RUN    = 3;
    localparam int M_PAUSE  = 4;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        run_en     = 1'b0;
    logic        resync     = 1'b0;
    logic        cfg_valid  = 1'b0;
    logic [15:0] cfg_settle = 16'd0;
    logic        cfg_ready;
    logic        flt_reset;
    logic        flt_enable;
    logic        out_valid;
    logic        busy;
    logic [2:0]  state_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: current mode, settle length in force, edge timestamp at which
    // the current FLUSH/SETTLE interval expires.
    int     m_mode   = M_IDLE;
    int     m_settle = DEF_SETL;
    longint m_deadline = 0;
    longint edge_cnt = 0;

    int s_n, s_first_en, s_rst, s_ready;

    lpf_run_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .run_en     (run_en),
        .resync     (resync),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_settle (cfg_settle),
        .flt_reset  (flt_reset),
        .flt_enable (flt_enable),
        .out_valid  (out_valid),
        .busy       (busy),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return !(m_mode == M_FLUSH || m_mode == M_SETTLE);
    endfunction

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_settle = DEF_SETL;
    endtask

    // One clock edge of the behavioural model using the inputs present at the edge.
    task automatic model_step();
        int nxt;
        bit acc;
        acc = cfg_valid && model_ready();
        nxt = m_mode;
        if (resync && m_mode != M_IDLE) begin
            nxt        = M_FLUSH;
            m_deadline = edge_cnt + FLUSH_N;
        end else if (!run_en) begin
            if (m_mode == M_RUN) nxt = M_PAUSE;
            else if (m_mode == M_FLUSH || m_mode == M_SETTLE) nxt = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    nxt        = M_FLUSH;
                    m_deadline = edge_cnt + FLUSH_N;
                end
                M_PAUSE: nxt = M_RUN;
                M_FLUSH: if (edge_cnt == m_deadline) begin
                    nxt        = M_SETTLE;
                    m_deadline = edge_cnt + ((m_settle == 0) ? 1 : m_settle);
                end
                M_SETTLE: if (edge_cnt == m_deadline) nxt = M_RUN;
                default: nxt = m_mode;
            endcase
        end
        if (acc) m_settle = int'(cfg_settle);
        m_mode = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        edge_cnt++;
        #1;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("state_o", 32'(state_o), 32'(m_mode));
        check("flt_reset", 32'(flt_reset), 32'(m_mode == M_IDLE || m_mode == M_FLUSH));
        check("flt_enable", 32'(flt_enable), 32'(m_mode == M_SETTLE || m_mode == M_RUN));
        check("out_valid", 32'(out_valid), 32'(m_mode == M_RUN));
        check("busy", 32'(busy), 32'(m_mode == M_FLUSH || m_mode == M_SETTLE));
        check("cfg_ready", 32'(cfg_ready), 32'(model_ready()));
    end

    task automatic clear_stats();
        s_n = 0; s_first_en = 0; s_rst = 0; s_ready = 0;
    endtask

    task automatic wait_valid(input int limit);
        do begin
            tick();
            resync = 1'b0;
            s_n++;
            if (s_first_en == 0 && flt_enable) s_first_en = s_n;
            if (flt_reset) s_rst++;
            if (cfg_ready && !out_valid) s_ready++;
        end while (!out_valid && s_n < limit);
    endtask

    task automatic go_idle();
        run_en = 1'b0;
        resync = 1'b1;
        tick();
        resync = 1'b0;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        model_reset();
        repeat (3) tick();
        check("reset_state", 32'(state_o), 32'd0);
        check("reset_flt_reset", 32'(flt_reset), 32'd1);
        check("reset_cfg_ready", 32'(cfg_ready), 32'd1);
        reset = 1'b0;

        // Default start-up: 1 + 4 + 2048 cycles to out_valid.
        run_en = 1'b1;
        clear_stats();
        wait_valid(3000);
        check("startup_latency", 32'(s_n), 32'd2053);
        check("startup_first_enable", 32'(s_first_en), 32'd5);
        check("startup_flush_cycles", 32'(s_rst), 32'd4);
        check("startup_busy_in_run", 32'(busy), 32'd0);

        // Pause for 20 cycles, resume without a flush.
        run_en = 1'b0;
        tick();
        check("pause_state", 32'(state_o), 32'd4);
        check("pause_out_valid", 32'(out_valid), 32'd0);
        check("pause_flt_enable", 32'(flt_enable), 32'd0);
        check("pause_flt_reset", 32'(flt_reset), 32'd0);
        cnt = 0;
        repeat (19) begin
            tick();
            if (flt_reset) cnt++;
        end
        run_en = 1'b1;
        tick();
        if (flt_reset) cnt++;
        check("pause_no_flush", 32'(cnt), 32'd0);
        check("resume_out_valid", 32'(out_valid), 32'd1);

        // Resync in RUN with a new settle value offered during the re-settle.
        clear_stats();
        resync = 1'b1;
        wait_valid(1);
        check("resync_out_valid", 32'(out_valid), 32'd0);
        check("resync_state", 32'(state_o), 32'd1);
        cfg_valid  = 1'b1;
        cfg_settle = 16'd100;
        wait_valid(3000);
        check("resync_latency", 32'(s_n), 32'd2053);
        check("resync_flush_cycles", 32'(s_rst), 32'd4);
        check("cfg_stalled_while_busy", 32'(s_ready), 32'd0);
        check("cfg_ready_first_run", 32'(cfg_ready), 32'd1);
        tick();
        cfg_valid = 1'b0;
        cnt = 0;
        repeat (5) begin
            tick();
            if (out_valid) cnt++;
        end
        check("run_uninterrupted", 32'(cnt), 32'd5);
        clear_stats();
        resync = 1'b1;
        wait_valid(500);
        check("resync_settle100", 32'(s_n), 32'd105);
        check("resync_settle100_enable", 32'(s_first_en), 32'd5);

        // Resync ignored in IDLE.
        go_idle();
        check("idle_reached", 32'(state_o), 32'd0);
        resync = 1'b1;
        tick();
        resync = 1'b0;
        check("idle_resync_ignored", 32'(state_o), 32'd0);

        // Settle 10 and 0 from IDLE.
        cfg_valid  = 1'b1;
        cfg_settle = 16'd10;
        check("idle_cfg_ready", 32'(cfg_ready), 32'd1);
        tick();
        cfg_valid = 1'b0;
        run_en    = 1'b1;
        clear_stats();
        wait_valid(100);
        check("settle10_latency", 32'(s_n), 32'd15);
        go_idle();
        cfg_valid  = 1'b1;
        cfg_settle = 16'd0;
        tick();
        cfg_valid = 1'b0;
        run_en    = 1'b1;
        clear_stats();
        wait_valid(100);
        check("settle0_latency", 32'(s_n), 32'd6);

        // Asynchronous reset in SETTLE restores defaults immediately.
        go_idle();
        cfg_valid  = 1'b1;
        cfg_settle = 16'd50;
        tick();
        cfg_valid = 1'b0;
        run_en    = 1'b1;
        repeat (6) tick();
        check("pre_reset_settle", 32'(state_o), 32'd2);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_state", 32'(state_o), 32'd0);
        check("async_flt_reset", 32'(flt_reset), 32'd1);
        check("async_flt_enable", 32'(flt_enable), 32'd0);
        tick();
        reset = 1'b0;
        clear_stats();
        wait_valid(3000);
        check("post_reset_default_settle", 32'(s_n), 32'd2053);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bit take;
            if ($urandom_range(0, 799) == 0) begin
                reset = 1'b1;
                model_reset();
                tick();
                reset = 1'b0;
            end
            if (run_en) begin
                if ($urandom_range(0, 59) == 0) run_en = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                run_en = 1'b1;
            end
            resync = ($urandom_range(0, 49) == 0);
            if (!cfg_valid && $urandom_range(0, 14) == 0) begin
                cfg_valid  = 1'b1;
                cfg_settle = 16'($urandom_range(0, 40));
            end
            take = cfg_valid && model_ready();
            tick();
            if (take) cfg_valid = 1'b0;
        end
        resync    = 1'b0;
        cfg_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
